// File: rtl/jtopl_pkg.sv
// Shared encodings and default chip timings for the OPL register-port write sequencer.
package jtopl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_AWAIT = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DWAIT = 3'd4;

  localparam int OPL_ADDR_WAIT = 12;
  localparam int OPL_DATA_WAIT = 84;

  typedef struct packed {
    logic [7:0] regn;
    logic [7:0] val;
  } wr_req_t;

endpackage

// File: rtl/jtopl_wrseq_fifo.sv
// Small synchronous FIFO; a push while full is dropped and reported on 'drop'.
module jtopl_wrseq_fifo #(
  parameter int AW = 3,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // full comes from the registered level, so a same-cycle pop cannot make room
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtopl_wrseq.sv
// Replays queued (register, value) writes onto the OPL pins as address/data
// phase strobes, holding the chip's busy time after each phase.
module jtopl_wrseq
  import jtopl_pkg::*;
#(
  parameter int AW        = 3,
  parameter int ADDR_WAIT = OPL_ADDR_WAIT,
  parameter int DATA_WAIT = OPL_DATA_WAIT,
  parameter int SKIP_ADDR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          req_we,
  input  logic [7:0]    req_reg,
  input  logic [7:0]    req_val,
  input  logic          clr_ovf,
  output logic          full,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          ovf,
  output logic          opl_write,
  output logic          opl_addr,
  output logic [7:0]    opl_din
);

  if (ADDR_WAIT < 0 || ADDR_WAIT > 255) begin : g_bad_addr_wait
    $error("jtopl_wrseq: ADDR_WAIT=%0d does not fit the 8-bit wait counter", ADDR_WAIT);
  end
  if (DATA_WAIT < 0 || DATA_WAIT > 255) begin : g_bad_data_wait
    $error("jtopl_wrseq: DATA_WAIT=%0d does not fit the 8-bit wait counter", DATA_WAIT);
  end

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] cnt;
  logic [7:0] hold_reg;
  logic [7:0] hold_val;
  logic [7:0] last_reg;
  logic       last_valid;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_drop;
  wr_req_t    fifo_din;
  wr_req_t    fifo_dout;

  assign fifo_din = '{regn: req_reg, val: req_val};

  jtopl_wrseq_fifo #(.AW(AW), .DW(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_we),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The address phase is skipped when the chip already has this register selected
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (SKIP_ADDR != 0 && last_valid && fifo_dout.regn == last_reg)
            state_nxt = ST_DATA;
          else
            state_nxt = ST_ADDR;
        end
      end
      ST_ADDR:  state_nxt = ST_AWAIT;
      ST_AWAIT: if (cnt == 8'd0) state_nxt = ST_DATA;
      ST_DATA:  state_nxt = ST_DWAIT;
      ST_DWAIT: if (cnt == 8'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 8'd0;
      hold_reg   <= 8'd0;
      hold_val   <= 8'd0;
      last_reg   <= 8'd0;
      last_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (pop) begin
        hold_reg <= fifo_dout.regn;
        hold_val <= fifo_dout.val;
      end
      case (state)
        ST_ADDR: begin
          cnt        <= 8'(ADDR_WAIT);
          last_reg   <= hold_reg;
          last_valid <= 1'b1;
        end
        ST_DATA: cnt <= 8'(DATA_WAIT);
        ST_AWAIT, ST_DWAIT: if (cen && cnt != 8'd0) cnt <= cnt - 8'd1;
        default: cnt <= cnt;
      endcase
      // A drop in the same cycle as a clear keeps the flag set
      if (fifo_drop)    ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_comb begin
    opl_write = 1'b0;
    opl_addr  = 1'b0;
    opl_din   = 8'd0;
    case (state)
      ST_ADDR: begin
        opl_write = 1'b1;
        opl_din   = hold_reg;
      end
      ST_DATA: begin
        opl_write = 1'b1;
        opl_addr  = 1'b1;
        opl_din   = hold_val;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE) || (level != '0);

endmodule

// File: doc/jtopl_wrseq.md
Name: jtopl_wrseq

Overview:
- CPU-side initiator for the OPL register port. It queues (register, value) write requests in a small FIFO.
- It replays each request onto the chip's addr/din/write pins as an address-phase write followed by a data-phase write.
- After each phase it holds for the chip's required busy time, counted in cen ticks.
- Sits between a sequencer or player (or a CPU glue block) and the jtopl top level. It drives the same pins the register decoder samples on every clk.

Parameters:
- AW, 3, log2 of FIFO depth (depth = 2**AW entries).
- ADDR_WAIT, 12, cen ticks to wait after an address-phase write (0..255).
- DATA_WAIT, 84, cen ticks to wait after a data-phase write (0..255).
- SKIP_ADDR, 1, when 1, omit the address phase if the register equals the last one selected.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  chip clock enable; the wait counters advance only when cen=1
- req_we  in  1  push request; ignored when full
- req_reg  in  8  register number to write
- req_val  in  8  value to write
- clr_ovf  in  1  clears the ovf flag
- full  out  1  FIFO level == 2**AW
- level  out  AW+1  number of queued entries (excludes the entry in flight)
- busy  out  1  FSM not in IDLE, or level != 0
- ovf  out  1  sticky flag: a push was dropped
- opl_write  out  1  one-clk write strobe to the chip
- opl_addr  out  1  0 = address phase, 1 = data phase
- opl_din  out  8  bus data; 0 whenever opl_write=0

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; level=0, full=0, ovf=0, busy=0.
  - FSM in IDLE; opl_write=0, opl_addr=0, opl_din=0.
  - Wait counter cleared; last_valid cleared.
  - Takes effect immediately, including mid-phase; an in-flight request is lost.
- FIFO:
  - Synchronous push on req_we && !full.
  - Push while full is dropped and sets ovf, even if a pop occurs in the same cycle. full is evaluated from the registered level.
  - Simultaneous push and pop leaves level unchanged.
  - ovf: clr_ovf clears it; a drop in the same cycle as clr_ovf wins (ovf=1).
  - Read/write pointers are AW bits and wrap modulo depth.
- FSM states: IDLE, ADDR, AWAIT, DATA, DWAIT.
  - IDLE: if level!=0, pop the head into hold_reg/hold_val.
    - If SKIP_ADDR && last_valid && head.reg==last_reg, go to DATA.
    - Otherwise go to ADDR.
    - A request pushed into an empty FIFO is popped on the next clk at the earliest.
  - ADDR (1 clk): opl_write=1, opl_addr=0, opl_din=hold_reg. Load cnt=ADDR_WAIT, set last_reg=hold_reg, last_valid=1, go to AWAIT.
  - AWAIT: if cnt==0, go to DATA; else if cen, cnt-=1. With WAIT=0 the state lasts exactly 1 clk.
  - DATA (1 clk): opl_write=1, opl_addr=1, opl_din=hold_val. Load cnt=DATA_WAIT, go to DWAIT.
  - DWAIT: same rule as AWAIT; exits to IDLE.
- Strobes:
  - The address-phase and data-phase strobes are never adjacent; at least one clk with opl_write=0 always separates them.
  - opl_addr and opl_din are driven only during the strobe cycle; they are 0 otherwise.
- Timing:
  - Minimum request-to-data-strobe latency with an empty FIFO and cen tied high: 1 (pop) + 1 (ADDR) + ADDR_WAIT+1 (AWAIT) = ADDR_WAIT+3 clks from the push cycle's edge.
- Counter is 8 bits. A parameter greater than 255 is a configuration error: an initial check reports it in simulation.

Decomposition:
- Shared package jtopl_pkg holds:
  - FSM state encoding (3-bit localparams ST_IDLE..ST_DWAIT).
  - Default wait constants OPL_ADDR_WAIT=12 and OPL_DATA_WAIT=84.
- One natural sub-module, jtopl_wrseq_fifo: a parameterised sync FIFO, 16-bit entries, async reset, with level/full/empty outputs.
- The FSM and counter stay in jtopl_wrseq.

Test Plan:
- Reset, then push (0x20,0x01), cen=1, ADDR_WAIT=12 → address strobe with din=0x20, addr=0. Data strobe with din=0x01, addr=1 exactly 14 clks later. busy=0 after 85 more clks.
- Push (0xA0,0x44) then (0xA0,0x55) with SKIP_ADDR=1 → a single address strobe (0xA0) and two data strobes (0x44, 0x55) spaced DATA_WAIT+3 clks apart. With SKIP_ADDR=0 → two address strobes.
- cen pulsing 1-in-4, ADDR_WAIT=2 → AWAIT exits only after 2 cen ticks have been counted and cnt==0; the strobe gap varies with cen phase but is always ≥ 3 clks.
- Fill 8 entries while stalled in DWAIT, push a 9th → full=1, level=8, ovf=1, 9th entry never appears on the bus. Assert clr_ovf → ovf=0.
- Push and pop in the same clk at level=3 → level stays 3. Push while full coinciding with a pop → dropped, ovf=1, level=7.
- Assert rst during AWAIT → all outputs 0 immediately. After release, the first request issues its address phase even if its reg equals the pre-reset last_reg.
